arq_retx_ctrl: RTL and testbench
================================

# arq_retx_ctrl

Stop-and-wait ARQ transmit controller that sequences the 4-bit transmit FIFO onto the link. It pops one word, holds it, and presents it with an alternating sequence bit. It then waits for a response code and retransmits on NACK, corrupt-ACK or timeout, up to a retry limit. It sits between the FIFO read port and the link/error-injection path in the top-level user project.

## Interface

Parameters:
- DATA_W, 4, payload width
- MAX_RETRY, 3, retransmissions allowed per word before drop (1..15)
- TIMEOUT, 8, cycles spent in WAIT without a response before timeout (2..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- fifo_empty  in  1  FIFO has no data
- fifo_rd_en  out  1  one-cycle pop strobe
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en
- tx_valid  out  1  word offered to link
- tx_data  out  DATA_W  held word
- tx_seq  out  1  alternating sequence bit of the held word
- tx_ready  in  1  link accepts word when tx_valid & tx_ready
- rsp_valid  in  1  response strobe
- rsp_code  in  2  00 ACK, 01 CORRUPT, 10 NACK, 11 reserved
- ack_pulse  out  1  word delivered
- drop_pulse  out  1  word abandoned after MAX_RETRY
- retry_cnt  out  4  retransmissions of the current word
- err_cnt  out  8  saturating count of CORRUPT + NACK + timeout events
- busy  out  1  state != IDLE

## Operation

- States: IDLE, FETCH, LOAD, SEND, WAIT.
- IDLE: if !fifo_empty -> FETCH.
- FETCH: fifo_rd_en=1 for exactly this cycle -> LOAD.
- LOAD: hold_reg <= fifo_rd_data -> SEND.
- SEND: tx_valid=1, tx_data=hold_reg, tx_seq=seq. On tx_ready: timer cleared -> WAIT. tx_data is stable while tx_valid is high.
- WAIT: timer increments each cycle.
  - rsp ACK: seq toggles, retry_cnt<=0, ack_pulse -> IDLE.
  - rsp CORRUPT or NACK: retransmit event.
  - Timer reaches TIMEOUT-1 with no response: retransmit event.
  - rsp 11: ignored (timer continues).
- Retransmit event: err_cnt += 1 (saturates at 255).
  - retry_cnt < MAX_RETRY: retry_cnt += 1 -> SEND (same hold_reg, same seq).
  - retry_cnt == MAX_RETRY: drop_pulse, seq toggles, retry_cnt<=0 -> IDLE.
- rsp_valid outside WAIT: ignored entirely.
- Response and timeout in the same cycle: the response wins; timeout is not counted.
- fifo_rd_en is never asserted while hold_reg holds an unresolved word.

## Timing

- Reset (async, rst_n=0): state IDLE; all outputs 0; seq=0, hold_reg=0, timer=0, retry_cnt=0, err_cnt=0.
- Reset mid-operation discards the held word (it is already popped from the FIFO).
- fifo_empty low in IDLE at cycle N -> fifo_rd_en in N+1 -> tx_valid from N+3.
- tx_ready already high in SEND: WAIT entered the next cycle (SEND lasts 1 cycle minimum).
- Earliest ACK: first WAIT cycle. ACK -> IDLE next cycle; back-to-back words are 5 cycles apart minimum.
- Timeout: the TIMEOUT-th WAIT cycle with no response triggers the retransmit; SEND follows the next cycle.
- ack_pulse and drop_pulse are registered, 1 cycle wide, and mutually exclusive.

## Structure

- Shared package arq_pkg holds:
  - rsp_code_e: ACK=2'b00, CORRUPT=2'b01, NACK=2'b10, RSVD=2'b11.
  - arq_state_e.
  - Default constants for DATA_W, MAX_RETRY and TIMEOUT.
- One sub-module, arq_timeout_timer: clear/enable inputs, expire output, width $clog2(TIMEOUT+1).
- The FSM, retry counter, seq bit and err_cnt stay in arq_retx_ctrl.

## Test plan

- Reset then FIFO holds 0x0, 0xA, tx_ready=1, ACK on first WAIT cycle each time -> tx_data 0x0 seq 0, then 0xA seq 1; two ack_pulses; err_cnt=0.
- Word 0x3, rsp NACK then ACK -> tx_data 0x3 sent twice with seq unchanged; retry_cnt 1; err_cnt=1; one ack_pulse.
- Word 0x2, rsp CORRUPT x4 with MAX_RETRY=3 -> 4 transmissions, then drop_pulse; seq toggles; err_cnt=4; next FIFO word is popped.
- No response, TIMEOUT=8 -> retransmit 8 cycles after WAIT entry; rsp_valid in the same cycle as expiry with ACK -> ack_pulse, err_cnt unchanged.
- tx_ready held low 5 cycles in SEND -> tx_valid/tx_data stable; no timer advance; rsp_valid during SEND ignored.
- Assert rst_n=0 mid-WAIT -> all outputs 0 immediately; after release, the controller resumes from IDLE with seq=0.

Source files
------------

// File: rtl/arq_pkg.sv
// arq_pkg: shared types and default constants for the stop-and-wait ARQ transmitter.
package arq_pkg;

    typedef enum logic [1:0] {
        RSP_ACK     = 2'b00,
        RSP_CORRUPT = 2'b01,
        RSP_NACK    = 2'b10,
        RSP_RSVD    = 2'b11
    } rsp_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } arq_state_e;

    localparam int DATA_W_DEF    = 4;
    localparam int MAX_RETRY_DEF = 3;
    localparam int TIMEOUT_DEF   = 8;

endpackage

// File: rtl/arq_timeout_timer.sv
// arq_timeout_timer: counts response-wait cycles; expire flags the TIMEOUT-th enabled cycle.
module arq_timeout_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= count + TW'(1);
    end

    assign expire = en && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/arq_retx_ctrl.sv
// arq_retx_ctrl: stop-and-wait ARQ transmit controller; pops a FIFO word, sends it with an
// alternating sequence bit and retransmits on NACK/CORRUPT/timeout up to MAX_RETRY times.
module arq_retx_ctrl
    import arq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_seq,
    input  logic              tx_ready,
    input  logic              rsp_valid,
    input  logic [1:0]        rsp_code,
    output logic              ack_pulse,
    output logic              drop_pulse,
    output logic [3:0]        retry_cnt,
    output logic [7:0]        err_cnt,
    output logic              busy
);
    arq_state_e        state;
    logic              seq;
    logic [DATA_W-1:0] hold_reg;
    logic              tmr_clear;
    logic              tmr_en;
    logic              expire;
    logic              rsp_ack;
    logic              rsp_err;
    logic              retx;

    assign tx_data   = hold_reg;
    assign tx_seq    = seq;
    assign busy      = state != ST_IDLE;
    assign tmr_clear = (state == ST_SEND) && tx_ready;
    assign tmr_en    = state == ST_WAIT;
    assign rsp_ack   = rsp_valid && (rsp_code_e'(rsp_code) == RSP_ACK);
    assign rsp_err   = rsp_valid && (rsp_code_e'(rsp_code) == RSP_CORRUPT ||
                                     rsp_code_e'(rsp_code) == RSP_NACK);
    // A real response in the expiry cycle suppresses the timeout; reserved codes do not.
    assign retx      = rsp_err || (expire && !rsp_ack);

    arq_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .en     (tmr_en),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            seq        <= 1'b0;
            hold_reg   <= '0;
            fifo_rd_en <= 1'b0;
            tx_valid   <= 1'b0;
            ack_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
            retry_cnt  <= '0;
            err_cnt    <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            ack_pulse  <= 1'b0;
            drop_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state      <= ST_FETCH;
                        fifo_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    hold_reg <= fifo_rd_data;
                    tx_valid <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rsp_ack) begin
                        seq       <= ~seq;
                        retry_cnt <= '0;
                        ack_pulse <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (retx) begin
                        err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        if (retry_cnt < 4'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            tx_valid  <= 1'b1;
                            state     <= ST_SEND;
                        end else begin
                            drop_pulse <= 1'b1;
                            seq        <= ~seq;
                            retry_cnt  <= '0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arq_retx_ctrl.sv
// tb_arq_retx_ctrl: directed checks of the ARQ controller against hand-computed expectations.
module tb_arq_retx_ctrl;
    logic       clk;
    logic       rst_n;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [3:0] fifo_rd_data;
    logic       tx_valid;
    logic [3:0] tx_data;
    logic       tx_seq;
    logic       tx_ready;
    logic       rsp_valid;
    logic [1:0] rsp_code;
    logic       ack_pulse;
    logic       drop_pulse;
    logic [3:0] retry_cnt;
    logic [7:0] err_cnt;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [3:0] mem [16];
    int wr = 0;
    int rd = 0;

    arq_retx_ctrl #(
        .DATA_W    (4),
        .MAX_RETRY (3),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_seq       (tx_seq),
        .tx_ready     (tx_ready),
        .rsp_valid    (rsp_valid),
        .rsp_code     (rsp_code),
        .ack_pulse    (ack_pulse),
        .drop_pulse   (drop_pulse),
        .retry_cnt    (retry_cnt),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: read data appears the cycle after the pop strobe
    assign fifo_empty = (wr == rd);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd % 16];
            rd <= rd + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        mem[wr % 16] = d;
        wr++;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        while (!tx_valid && n < 16) begin
            step();
            n++;
        end
        chk("tx_wait", tx_valid, 1);
    endtask

    task automatic rsp(input logic [1:0] code);
        rsp_valid = 1'b1;
        rsp_code  = code;
        step();
        rsp_valid = 1'b0;
        rsp_code  = 2'b00;
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        tx_ready     = 1'b1;
        rsp_valid    = 1'b0;
        rsp_code     = 2'b00;
        fifo_rd_data = 4'h0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_rden", fifo_rd_en, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_seq", tx_seq, 0);

        // two words, immediate ACK each
        push(4'h0);
        push(4'hA);
        rst_n = 1'b1;
        step();
        chk("t1_rden", fifo_rd_en, 1);
        step();
        chk("t1_rden_1cyc", fifo_rd_en, 0);
        step();
        chk("t1_txv", tx_valid, 1);
        chk("t1_data0", tx_data, 4'h0);
        chk("t1_seq0", tx_seq, 0);
        step();
        chk("t1_wait_txv", tx_valid, 0);
        rsp(2'b00);
        chk("t1_ack0", ack_pulse, 1);
        chk("t1_busy_idle", busy, 0);
        wait_tx(n);
        chk("t1_gap", n, 3);
        chk("t1_dataA", tx_data, 4'hA);
        chk("t1_seq1", tx_seq, 1);
        step();
        rsp(2'b00);
        chk("t1_ack1", ack_pulse, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_seq_back", tx_seq, 0);

        // NACK then ACK
        push(4'h3);
        wait_tx(n);
        chk("t2_data", tx_data, 4'h3);
        chk("t2_seq", tx_seq, 0);
        step();
        rsp(2'b10);
        chk("t2_resend", tx_valid, 1);
        chk("t2_data_again", tx_data, 4'h3);
        chk("t2_seq_same", tx_seq, 0);
        chk("t2_retry", retry_cnt, 1);
        chk("t2_err", err_cnt, 1);
        chk("t2_no_ack", ack_pulse, 0);
        step();
        rsp(2'b00);
        chk("t2_ack", ack_pulse, 1);
        chk("t2_retry_clr", retry_cnt, 0);
        chk("t2_seq_tog", tx_seq, 1);

        // CORRUPT x4 -> drop, then next word popped
        push(4'h2);
        push(4'h5);
        wait_tx(n);
        chk("t3_data", tx_data, 4'h2);
        chk("t3_seq", tx_seq, 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            rsp(2'b01);
            chk("t3_resend", tx_valid, 1);
            chk("t3_retry", retry_cnt, i);
            chk("t3_seq_same", tx_seq, 1);
            chk("t3_data_same", tx_data, 4'h2);
        end
        step();
        rsp(2'b01);
        chk("t3_drop", drop_pulse, 1);
        chk("t3_drop_noack", ack_pulse, 0);
        chk("t3_drop_txv", tx_valid, 0);
        chk("t3_drop_seq", tx_seq, 0);
        chk("t3_drop_retry", retry_cnt, 0);
        chk("t3_err", err_cnt, 5);
        step();
        chk("t3_next_pop", fifo_rd_en, 1);
        chk("t3_drop_1cyc", drop_pulse, 0);

        // timeout retransmit, then ACK coinciding with expiry
        wait_tx(n);
        chk("t4_data", tx_data, 4'h5);
        chk("t4_seq", tx_seq, 0);
        step();
        for (int i = 0; i < 7; i++) step();
        chk("t4_pre_to_txv", tx_valid, 0);
        chk("t4_pre_to_err", err_cnt, 5);
        step();
        chk("t4_to_txv", tx_valid, 1);
        chk("t4_to_retry", retry_cnt, 1);
        chk("t4_to_err", err_cnt, 6);
        step();
        for (int i = 0; i < 7; i++) step();
        rsp(2'b00);
        chk("t4_ack_win", ack_pulse, 1);
        chk("t4_err_keep", err_cnt, 6);
        chk("t4_txv", tx_valid, 0);
        chk("t4_seq_tog", tx_seq, 1);

        // tx_ready stalled in SEND, responses ignored there
        tx_ready = 1'b0;
        push(4'h9);
        wait_tx(n);
        rsp_valid = 1'b1;
        rsp_code  = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold_txv", tx_valid, 1);
            chk("t5_hold_data", tx_data, 4'h9);
            chk("t5_hold_err", err_cnt, 6);
        end
        rsp_valid = 1'b0;
        rsp_code  = 2'b00;
        tx_ready  = 1'b1;
        step();
        for (int i = 0; i < 7; i++) step();
        chk("t5_pre_to", tx_valid, 0);
        step();
        chk("t5_to_txv", tx_valid, 1);
        chk("t5_to_err", err_cnt, 7);
        chk("t5_to_retry", retry_cnt, 1);

        // async reset mid-WAIT
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_txv", tx_valid, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_seq", tx_seq, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_retry", retry_cnt, 0);
        push(4'h6);
        rst_n = 1'b1;
        wait_tx(n);
        chk("t6_lat", n, 3);
        chk("t6_data_new", tx_data, 4'h6);
        chk("t6_seq_new", tx_seq, 0);
        step();
        rsp(2'b00);
        chk("t6_ack", ack_pulse, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
